// File: rtl/id_ex_skid_reg.sv
// ---------------------------------------------------------------------------
// id_ex_skid_reg
//   ID->EX pipeline register for the RV32 core. It carries the decoded operands
//   and control for one instruction into the EX ALU stage.
//
//   There are two storage entries:
//     main entry : drives out_*.
//     skid entry : absorbs one op that arrives while EX is stalled.
//   With the skid entry, in_ready comes straight from a flop and never
//   combinationally from out_ready. A synchronous flush discards every held op.
//
// Parameters
//   XLEN      data / pc / immediate width
//   ALU_OP_W  alu_op width
//   RADDR_W   destination register index width
//
// Ports
//   clk, rst (async, active-high), flush (sync kill)
//   in_valid / in_ready   : ID-side handshake (in_ready registered)
//   in_rs1_data, in_rs2_data, in_imm, in_pc, in_alu_op, in_alu_rs2_imm,
//   in_rd, in_reg_write   : decoded op fields
//   out_valid / out_ready : EX-side handshake
//   out_*                 : registered copies of the eight in_* fields
// ---------------------------------------------------------------------------
module id_ex_skid_reg #(
  parameter int XLEN     = 32,
  parameter int ALU_OP_W = 4,
  parameter int RADDR_W  = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,

  input  logic                in_valid,
  output logic                in_ready,
  input  logic [XLEN-1:0]     in_rs1_data,
  input  logic [XLEN-1:0]     in_rs2_data,
  input  logic [XLEN-1:0]     in_imm,
  input  logic [XLEN-1:0]     in_pc,
  input  logic [ALU_OP_W-1:0] in_alu_op,
  input  logic                in_alu_rs2_imm,
  input  logic [RADDR_W-1:0]  in_rd,
  input  logic                in_reg_write,

  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     out_rs1_data,
  output logic [XLEN-1:0]     out_rs2_data,
  output logic [XLEN-1:0]     out_imm,
  output logic [XLEN-1:0]     out_pc,
  output logic [ALU_OP_W-1:0] out_alu_op,
  output logic                out_alu_rs2_imm,
  output logic [RADDR_W-1:0]  out_rd,
  output logic                out_reg_write
);

  localparam int PW = 4*XLEN + ALU_OP_W + RADDR_W + 2;

  // The encoding is chosen so that bit 0 is the main-entry valid flag and
  // bit 1 is the skid-entry valid flag. Both handshake outputs are then a
  // single flop bit with no decode logic in front of them.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    TWO   = 2'b11
  } occ_e;

  occ_e          state, state_nxt;
  logic          m_v, s_v;
  logic          acc, deq;
  logic          m_load_in, m_load_skid, s_load_in;

  logic [PW-1:0] in_word;
  logic [PW-1:0] main_p1;
  logic [PW-1:0] skid_p1;

  assign in_word = {in_rs1_data, in_rs2_data, in_imm, in_pc,
                    in_alu_op, in_alu_rs2_imm, in_rd, in_reg_write};

  assign m_v       = state[0];
  assign s_v       = state[1];
  assign in_ready  = ~s_v;
  assign out_valid = m_v;

  assign acc = in_valid & in_ready;
  assign deq = m_v & out_ready;

  // Next-state and load enables. A flush overrides every other event: the
  // state returns to EMPTY and a same-cycle accept loads nothing. The data
  // registers are left stale because the valid flags already mark them dead.
  always_comb begin
    state_nxt   = state;
    m_load_in   = 1'b0;
    m_load_skid = 1'b0;
    s_load_in   = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (acc) begin
            m_load_in = 1'b1;
            state_nxt = ONE;
          end
        end
        ONE: begin
          if (deq && acc) begin
            m_load_in = 1'b1;
          end else if (deq) begin
            state_nxt = EMPTY;
          end else if (acc) begin
            // EX is stalled, so the new op parks in the skid entry.
            s_load_in = 1'b1;
            state_nxt = TWO;
          end
        end
        TWO: begin
          // in_ready is low in this state, so only a dequeue can happen.
          if (deq) begin
            m_load_skid = 1'b1;
            state_nxt   = ONE;
          end
        end
        default: begin
          state_nxt = EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // ---- stage p1: main and skid data entries ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_p1 <= '0;
    end else if (m_load_in) begin
      main_p1 <= in_word;
    end else if (m_load_skid) begin
      main_p1 <= skid_p1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_p1 <= '0;
    end else if (s_load_in) begin
      skid_p1 <= in_word;
    end
  end

  assign {out_rs1_data, out_rs2_data, out_imm, out_pc,
          out_alu_op, out_alu_rs2_imm, out_rd, out_reg_write} = main_p1;

endmodule
